// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator: turns single/burst client commands into
// classic or CTI/BTE bus cycles. It streams write and read data, retries
// after rty with a back-off gap, aborts on err, and aborts when the slave
// stays silent too long.
module wb_burst_master #(
  parameter int TIMEOUT   = 256,
  parameter int MAX_RETRY = 4,
  parameter int RTY_GAP   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [4:0]  cmd_len,
  input  logic [1:0]  cmd_bte,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GCW = (RTY_GAP > 1) ? $clog2(RTY_GAP) : 1;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BUS, S_GAP, S_END} state_t;

  state_t           state, state_d;
  logic [4:0]       beats;      // beats still to complete, including the one on the bus
  logic [WDW-1:0]   wdog;
  logic [RCW-1:0]   retry_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic [1:0]       sts_q, sts_d;
  logic             accept, issue, load_wd, advance, stall, retry, finish;
  logic             r_err, r_rty, r_ack;

  // Responses only count while the cycle is open; err beats rty beats ack
  assign r_err = wb_cyc_o & wb_err_i;
  assign r_rty = wb_cyc_o & wb_rty_i & ~wb_err_i;
  assign r_ack = wb_cyc_o & wb_ack_i & ~wb_err_i & ~wb_rty_i;

  // Wrap modes only step the low address bits inside the aligned block
  function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] bte);
    logic [31:0] n;
    case (bte)
      2'b01:   n = {a[31:4], a[3:2] + 2'd1, 2'b00};
      2'b10:   n = {a[31:5], a[4:2] + 3'd1, 2'b00};
      2'b11:   n = {a[31:6], a[5:2] + 4'd1, 2'b00};
      default: n = a + 32'd4;
    endcase
    return n;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state and handshake decode; the bus registers follow these strobes
  always_comb begin
    state_d   = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    done      = 1'b0;
    status    = 2'b00;
    accept    = 1'b0;
    issue     = 1'b0;
    load_wd   = 1'b0;
    advance   = 1'b0;
    stall     = 1'b0;
    retry     = 1'b0;
    finish    = 1'b0;
    sts_d     = ST_OK;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = cmd_we ? S_LOAD : S_BUS;
        end
      end
      S_LOAD: if (wr_valid) begin
        wr_ready = 1'b1;
        load_wd  = 1'b1;
        issue    = 1'b1;
        state_d  = S_BUS;
      end
      S_BUS: begin
        if (r_err) begin
          finish  = 1'b1;
          sts_d   = ST_ERR;
          state_d = S_END;
        end else if (r_rty) begin
          if (retry_cnt == RCW'(MAX_RETRY)) begin
            finish  = 1'b1;
            sts_d   = ST_RTY;
            state_d = S_END;
          end else begin
            retry   = 1'b1;
            state_d = S_GAP;
          end
        end else if (r_ack) begin
          if (beats == 5'd1) begin
            finish  = 1'b1;
            state_d = S_END;
          end else begin
            advance = 1'b1;
            if (wb_we_o) begin
              if (wr_valid) begin
                wr_ready = 1'b1;
                load_wd  = 1'b1;
              end else begin
                stall   = 1'b1;
                state_d = S_LOAD;
              end
            end
          end
        end else if (wdog == WDW'(TIMEOUT - 1)) begin
          finish  = 1'b1;
          sts_d   = ST_TMO;
          state_d = S_END;
        end
      end
      S_GAP: if (gap_cnt == '0) begin
        issue   = 1'b1;
        state_d = S_BUS;
      end
      S_END: begin
        done    = 1'b1;
        status  = sts_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus-side registers, command context and read return path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_cti_o  <= '0;
      wb_bte_o  <= '0;
      beats     <= '0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
      sts_q     <= ST_OK;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (state == S_BUS && r_ack && !wb_we_o) begin
        rd_valid <= 1'b1;
        rd_data  <= wb_dat_i;
      end
      if (accept) begin
        wb_adr_o  <= {cmd_adr[31:2], 2'b00};
        wb_we_o   <= cmd_we;
        wb_sel_o  <= cmd_sel;
        beats     <= (cmd_len == 5'd0) ? 5'd16 : cmd_len;
        wb_cti_o  <= (cmd_len == 5'd1) ? 3'b000 : 3'b010;
        wb_bte_o  <= (cmd_len == 5'd1) ? 2'b00 : cmd_bte;
        retry_cnt <= '0;
        // reads have nothing to wait for, strobe right away
        wb_cyc_o  <= ~cmd_we;
        wb_stb_o  <= ~cmd_we;
      end
      if (load_wd) wb_dat_o <= wr_data;
      if (issue) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end
      if (advance) begin
        wb_adr_o <= next_adr(wb_adr_o, wb_bte_o);
        beats    <= beats - 5'd1;
        wb_cti_o <= (beats == 5'd2) ? 3'b111 : 3'b010;
      end
      // write data ran dry: hold the cycle, withdraw the strobe
      if (stall) wb_stb_o <= 1'b0;
      if (retry) begin
        wb_cyc_o  <= 1'b0;
        wb_stb_o  <= 1'b0;
        retry_cnt <= retry_cnt + 1'b1;
        gap_cnt   <= GCW'(RTY_GAP - 1);
      end
      if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (finish) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_cti_o <= '0;
        wb_bte_o <= '0;
        sts_q    <= sts_d;
      end
    end
  end

  // Watchdog: consecutive strobed cycles without any slave response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              wdog <= '0;
    else if (state == S_BUS && !(r_ack || r_err || r_rty))   wdog <= wdog + 1'b1;
    else                                                     wdog <= '0;
  end

endmodule
